calc_seq_ctrl: RTL and testbench
================================

// Module: calc_seq_ctrl
// PURPOSE
//  Instruction sequencer for the smallCALC 4x3-bit register file. Accepts one command per
//  go pulse (LOAD/ADD/SUB/MOV), drives RF read/write enables and addresses, latches operands,
//  computes the 3-bit result and writes it back. Sits between the user input stage and the RF.
//  Multi-cycle, one command in flight; busy/done handshake.
// PARAMETERS
//  DW  3  data width; matches RF word width
//  AW  2  RF address width (2**AW registers)
// PORTS
//  clk     in   1   rising-edge clock
//  rst     in   1   asynchronous, active-high reset
//  go      in   1   start command; sampled only in IDLE
//  op      in   2   00 LOAD, 01 ADD, 10 SUB, 11 MOV
//  s1      in   AW  source A register address
//  s2      in   AW  source B register address (ADD/SUB only)
//  d       in   AW  destination register address
//  imm     in   DW  immediate data for LOAD
//  douta   in   DW  RF read port A data
//  doutb   in   DW  RF read port B data
//  rea     out  1   RF read enable A
//  reb     out  1   RF read enable B
//  raa     out  AW  RF read address A
//  rab     out  AW  RF read address B
//  we      out  1   RF write enable (one cycle per command)
//  wa      out  AW  RF write address
//  din     out  DW  RF write data
//  busy    out  1   high from cycle after accepted go until DONE state exits
//  done    out  1   one-cycle pulse, command complete
//  cflag   out  1   ADD carry-out / SUB borrow of the last arithmetic command
// BEHAVIOUR
//  - Cycle 0 = the edge at which go=1 is sampled in IDLE; command latched: op, s1, s2, d, imm.
//  - Reset (any time, incl. mid-command): state=IDLE; all outputs 0; latched fields, operand
//    regs, result reg, cflag = 0. Any write in progress is aborted (we drops immediately).
//    RF contents are not touched.
//  - States: IDLE, READ, EXEC, WRITE, DONE. All outputs Moore-decoded from registered state/regs.
//    IDLE  : go=1 -> LOAD: WRITE; else READ. go=0 -> stay.
//    READ  : rea=1, raa=s1; reb=1, rab=s2 only for ADD/SUB (MOV: reb=0). At exit edge,
//            opA<=douta, opB<=doutb (opB<=0 for MOV). -> EXEC.
//    EXEC  : ADD res={c,sum}=opA+opB; SUB res=opA-opB mod 2**DW, c=(opA<opB);
//            MOV res=opA, c unchanged. res/cflag registered at exit edge. -> WRITE.
//    WRITE : we=1, wa=d, din=res (LOAD: din=imm). Exactly one cycle. -> DONE.
//    DONE  : done=1 for one cycle. -> IDLE.
//  - Latency go-sample to done: LOAD 2 cycles, ADD/SUB/MOV 4 cycles. Next go accepted
//    the cycle after DONE (IDLE).
//  - busy=1 in READ, EXEC, WRITE, DONE; 0 in IDLE.
//  - go while busy: ignored, not queued. Input fields changing while busy: no effect.
//  - rea/reb/we = 0 and raa/rab/wa/din = 0 in every state where not listed above.
//  - Arithmetic wraps at 2**DW; no saturation. cflag changes only on ADD/SUB EXEC exit or reset.
//  - s1==d or s2==d allowed: operands are latched in READ before WRITE, so the old value is used.
//  - s1==s2 allowed (both ports read the same register).
// TESTING
//  1 rst pulse mid-ADD (in EXEC) -> all outputs 0 next cycle, state IDLE, no we pulse, cflag=0.
//  2 LOAD imm=5,d=2 -> we=1,wa=2,din=5 at cycle 1; done at cycle 2; RF[2]=5.
//  3 RF[1]=6,RF[2]=3; ADD s1=1,s2=2,d=3 -> din=1 (wrap), cflag=1, done at cycle 4.
//  4 RF[1]=2,RF[2]=5; SUB s1=1,s2=2,d=1 -> din=5 (2-5 mod 8), cflag=1, RF[1]=5 (self-dest).
//  5 MOV s1=0,d=3 with RF[0]=7 -> reb=0 throughout, RF[3]=7, cflag unchanged.
//  6 go held high continuously across 3 commands -> each accepted only in IDLE; 1 we/done per cmd.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// calc_seq_ctrl
//   Instruction sequencer for the smallCALC 4 x 3-bit register file. One command
//   (LOAD / ADD / SUB / MOV) is accepted per go pulse while idle. The sequencer
//   reads the source operands from the register file, computes a DW-bit result
//   and writes it back. Only one command is in flight at a time.
//
//   Sequence: IDLE -> READ -> EXEC -> WRITE -> DONE -> IDLE
//             (LOAD goes IDLE -> WRITE directly)
//
// Ports
//   clk    in   1   rising-edge clock
//   rst    in   1   asynchronous, active-high reset
//   go     in   1   start command, sampled only in IDLE
//   op     in   2   00 LOAD, 01 ADD, 10 SUB, 11 MOV
//   s1     in   AW  source A register address
//   s2     in   AW  source B register address (ADD/SUB only)
//   d      in   AW  destination register address
//   imm    in   DW  immediate data for LOAD
//   douta  in   DW  register file read port A data
//   doutb  in   DW  register file read port B data
//   rea    out  1   read enable A
//   reb    out  1   read enable B
//   raa    out  AW  read address A
//   rab    out  AW  read address B
//   we     out  1   write enable, one cycle per command
//   wa     out  AW  write address
//   din    out  DW  write data
//   busy   out  1   command in progress (READ/EXEC/WRITE/DONE)
//   done   out  1   one-cycle completion pulse
//   cflag  out  1   carry (ADD) / borrow (SUB) of the last arithmetic command
// -----------------------------------------------------------------------------
module calc_seq_ctrl #(
    parameter int DW = 3,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [1:0]    op,
    input  logic [AW-1:0] s1,
    input  logic [AW-1:0] s2,
    input  logic [AW-1:0] d,
    input  logic [DW-1:0] imm,
    input  logic [DW-1:0] douta,
    input  logic [DW-1:0] doutb,
    output logic          rea,
    output logic          reb,
    output logic [AW-1:0] raa,
    output logic [AW-1:0] rab,
    output logic          we,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] din,
    output logic          busy,
    output logic          done,
    output logic          cflag
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MOV  = 2'b11;

    state_t        state_q, state_d;
    logic [1:0]    op_q,    op_d;
    logic [AW-1:0] s1_q,    s1_d;
    logic [AW-1:0] s2_q,    s2_d;
    logic [AW-1:0] d_q,     d_d;
    logic [DW-1:0] imm_q,   imm_d;
    logic [DW-1:0] opa_q,   opa_d;
    logic [DW-1:0] opb_q,   opb_d;
    logic [DW-1:0] res_q,   res_d;
    logic          cflag_q, cflag_d;

    // ADD/SUB use read port B; LOAD and MOV leave it idle.
    logic          uses_b;
    assign uses_b = (op_q == OP_ADD) || (op_q == OP_SUB);

    // -------------------------------------------------------------------------
    // State and datapath registers. Reset clears everything, including the
    // latched command, so a reset mid-command drops any pending write.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            d_q     <= '0;
            imm_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            d_q     <= d_d;
            imm_q   <= imm_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cflag_q <= cflag_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and register updates
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        d_d     = d_q;
        imm_d   = imm_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cflag_d = cflag_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    op_d    = op;
                    s1_d    = s1;
                    s2_d    = s2;
                    d_d     = d;
                    imm_d   = imm;
                    state_d = (op == OP_LOAD) ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                // Operands are captured here, before WRITE, so a destination
                // that aliases a source still sees the old register value.
                opa_d   = douta;
                opb_d   = uses_b ? doutb : '0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD: {cflag_d, res_d} = {1'b0, opa_q} + {1'b0, opb_q};
                    OP_SUB: begin
                        res_d   = opa_q - opb_q;
                        cflag_d = (opa_q < opb_q);
                    end
                    default: res_d = opa_q;  // MOV keeps cflag
                endcase
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore outputs, decoded from registered state only
    // -------------------------------------------------------------------------
    always_comb begin
        rea  = 1'b0;
        reb  = 1'b0;
        raa  = '0;
        rab  = '0;
        we   = 1'b0;
        wa   = '0;
        din  = '0;
        done = 1'b0;
        busy = (state_q != S_IDLE);

        case (state_q)
            S_READ: begin
                rea = 1'b1;
                raa = s1_q;
                if (uses_b) begin
                    reb = 1'b1;
                    rab = s2_q;
                end
            end
            S_WRITE: begin
                we  = 1'b1;
                wa  = d_q;
                din = (op_q == OP_LOAD) ? imm_q : res_q;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign cflag = cflag_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl with a small register-file model attached.
module tb_calc_seq_ctrl;

    localparam int DW = 3;
    localparam int AW = 2;

    localparam logic [1:0] LD  = 2'b00;
    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] SUB = 2'b10;
    localparam logic [1:0] MOV = 2'b11;

    logic          clk;
    logic          rst;
    logic          go;
    logic [1:0]    op;
    logic [AW-1:0] s1, s2, d;
    logic [DW-1:0] imm;
    logic [DW-1:0] douta, doutb;
    logic          rea, reb, we, busy, done, cflag;
    logic [AW-1:0] raa, rab, wa;
    logic [DW-1:0] din;

    logic [DW-1:0] rf [4];

    int n_checks = 0;
    int n_errors = 0;

    calc_seq_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .go    (go),
        .op    (op),
        .s1    (s1),
        .s2    (s2),
        .d     (d),
        .imm   (imm),
        .douta (douta),
        .doutb (doutb),
        .rea   (rea),
        .reb   (reb),
        .raa   (raa),
        .rab   (rab),
        .we    (we),
        .wa    (wa),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .cflag (cflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational read, synchronous write.
    assign douta = rf[raa];
    assign doutb = rf[rab];
    always @(posedge clk) if (we) rf[wa] <= din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, scramble the inputs while busy, then trace 6 cycles.
    task automatic do_cmd(input string tag, input logic [1:0] op_v,
                          input logic [1:0] s1_v, input logic [1:0] s2_v,
                          input logic [1:0] d_v, input logic [2:0] imm_v,
                          input logic [2:0] exp_din, input logic exp_c);
        int we_cnt, done_cnt, we_cyc, done_cyc, reb_cnt;
        int exp_we_cyc, exp_done_cyc;
        logic [2:0] din_seen;
        logic [1:0] wa_seen;
        we_cnt = 0; done_cnt = 0; we_cyc = 0; done_cyc = 0; reb_cnt = 0;
        din_seen = '0; wa_seen = '0;
        exp_we_cyc   = (op_v == LD) ? 1 : 3;
        exp_done_cyc = (op_v == LD) ? 2 : 4;

        @(negedge clk);
        go = 1'b1; op = op_v; s1 = s1_v; s2 = s2_v; d = d_v; imm = imm_v;
        @(posedge clk);
        #1;
        go = 1'b0; op = ~op_v; s1 = ~s1_v; s2 = ~s2_v; d = ~d_v; imm = ~imm_v;

        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) chk({tag, "_busy1"}, 32'(busy), 32'd1);
            if (k == 1 && op_v != LD) begin
                chk({tag, "_rea"}, 32'(rea), 32'd1);
                chk({tag, "_raa"}, 32'(raa), 32'(s1_v));
                chk({tag, "_reb"}, 32'(reb), (op_v == MOV) ? 32'd0 : 32'd1);
                chk({tag, "_rab"}, 32'(rab), (op_v == MOV) ? 32'd0 : 32'(s2_v));
            end
            if (k == exp_done_cyc + 1) chk({tag, "_busy_end"}, 32'(busy), 32'd0);
            if (reb) reb_cnt++;
            if (we) begin
                we_cnt++; we_cyc = k; din_seen = din; wa_seen = wa;
            end
            if (done) begin
                done_cnt++; done_cyc = k;
            end
        end

        chk({tag, "_we_cnt"},   32'(we_cnt),   32'd1);
        chk({tag, "_we_cyc"},   32'(we_cyc),   32'(exp_we_cyc));
        chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done_cyc));
        chk({tag, "_wa"},       32'(wa_seen),  32'(d_v));
        chk({tag, "_din"},      32'(din_seen), 32'(exp_din));
        chk({tag, "_cflag"},    32'(cflag),    32'(exp_c));
        chk({tag, "_rf"},       32'(rf[d_v]),  32'(exp_din));
        if (op_v == MOV || op_v == LD) chk({tag, "_reb_cnt"}, 32'(reb_cnt), 32'd0);
    endtask

    initial begin
        int we_cnt, done_cnt, busy_cnt;
        rst = 1'b1; go = 1'b0; op = '0; s1 = '0; s2 = '0; d = '0; imm = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_we",    32'(we),    32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_rea",   32'(rea),   32'd0);
        chk("rst_reb",   32'(reb),   32'd0);
        chk("rst_din",   32'(din),   32'd0);
        chk("rst_wa",    32'(wa),    32'd0);
        chk("rst_cflag", 32'(cflag), 32'd0);
        rst = 1'b0;

        // LOAD imm=5 into r2
        do_cmd("load5", LD, 2'd0, 2'd0, 2'd2, 3'd5, 3'd5, 1'b0);

        // ADD with wrap: 6 + 3 = 9 -> 1, carry
        do_cmd("ld6",  LD,  2'd0, 2'd0, 2'd1, 3'd6, 3'd6, 1'b0);
        do_cmd("ld3",  LD,  2'd0, 2'd0, 2'd2, 3'd3, 3'd3, 1'b0);
        do_cmd("add",  ADD, 2'd1, 2'd2, 2'd3, 3'd0, 3'd1, 1'b1);

        // SUB with borrow, destination aliases source: 2 - 5 = 5 mod 8
        do_cmd("ld2",  LD,  2'd0, 2'd0, 2'd1, 3'd2, 3'd2, 1'b1);
        do_cmd("ld5",  LD,  2'd0, 2'd0, 2'd2, 3'd5, 3'd5, 1'b1);
        do_cmd("sub",  SUB, 2'd1, 2'd2, 2'd1, 3'd0, 3'd5, 1'b1);

        // MOV r0 -> r3, cflag stays 1
        do_cmd("ld7",  LD,  2'd0, 2'd0, 2'd0, 3'd7, 3'd7, 1'b1);
        do_cmd("mov",  MOV, 2'd0, 2'd1, 2'd3, 3'd0, 3'd7, 1'b1);

        // ADD with s1==s2, no carry: 1 + 1 = 2, cflag cleared
        do_cmd("ld1",  LD,  2'd0, 2'd0, 2'd0, 3'd1, 3'd1, 1'b1);
        do_cmd("add2", ADD, 2'd0, 2'd0, 2'd2, 3'd0, 3'd2, 1'b0);

        // SUB with borrow: 2 - 5 = 5, r0 <- 5
        do_cmd("sub2", SUB, 2'd2, 2'd1, 2'd0, 3'd0, 3'd5, 1'b1);

        // Reset in the middle of an ADD (during EXEC): r1=5, r2=2, r3=7
        @(negedge clk);
        go = 1'b1; op = ADD; s1 = 2'd1; s2 = 2'd2; d = 2'd3;
        @(posedge clk);
        #1 go = 1'b0;
        @(negedge clk);              // READ
        @(negedge clk);              // EXEC
        chk("mid_busy_exec", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_busy",  32'(busy),  32'd0);
        chk("mid_we",    32'(we),    32'd0);
        chk("mid_rea",   32'(rea),   32'd0);
        chk("mid_din",   32'(din),   32'd0);
        chk("mid_cflag", 32'(cflag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        we_cnt = 0; busy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (we)   we_cnt++;
            if (busy) busy_cnt++;
        end
        chk("mid_no_we",   32'(we_cnt),   32'd0);
        chk("mid_idle",    32'(busy_cnt), 32'd0);
        chk("mid_rf3",     32'(rf[3]),    32'd7);

        // SUB without borrow: 5 - 2 = 3
        do_cmd("sub3", SUB, 2'd1, 2'd2, 2'd0, 3'd0, 3'd3, 1'b0);

        // go held high across three ADD commands: r1 <- r0 + r0 = 6
        @(negedge clk);
        go = 1'b1; op = ADD; s1 = 2'd0; s2 = 2'd0; d = 2'd1;
        we_cnt = 0; done_cnt = 0; busy_cnt = 0;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk);
            if (c == 11) begin
                #1 go = 1'b0;
            end
            @(negedge clk);
            if (we)   we_cnt++;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        chk("hold_we",   32'(we_cnt),   32'd3);
        chk("hold_done", 32'(done_cnt), 32'd3);
        chk("hold_busy", 32'(busy_cnt), 32'd12);
        chk("hold_rf1",  32'(rf[1]),    32'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
